// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone classic arbiter in front of the shared SRAM slave.
// Round-robin per bus cycle, with a watchdog that aborts hung slave accesses.
module wb_ram_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_bus,
  input  logic              rst_bus,

  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [31:0]       m0_dat_i,
  output logic [31:0]       m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_rty_o,

  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [31:0]       m1_dat_i,
  output logic [31:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_rty_o,

  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [3:0]        s_sel_o,
  output logic [31:0]       s_dat_o,
  input  logic [31:0]       s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i
);

  localparam int unsigned       WDOG_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ABORT
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_pulse_q, err_pulse_d;

  logic              own_cyc, own_stb, own_we;
  logic [ADDR_W-1:0] own_adr;
  logic [3:0]        own_sel;
  logic [31:0]       own_dat;
  logic              grant;
  logic              term;
  logic              busy;
  logic              abort_err;

  always_comb begin
    if (owner_q) begin
      own_cyc = m1_cyc_i;
      own_stb = m1_stb_i;
      own_we  = m1_we_i;
      own_adr = m1_adr_i;
      own_sel = m1_sel_i;
      own_dat = m1_dat_i;
    end else begin
      own_cyc = m0_cyc_i;
      own_stb = m0_stb_i;
      own_we  = m0_we_i;
      own_adr = m0_adr_i;
      own_sel = m0_sel_i;
      own_dat = m0_dat_i;
    end
  end

  // On a tie the master that did not win last time gets the slave.
  assign grant     = (m0_cyc_i && m1_cyc_i) ? ~last_q : m1_cyc_i;
  assign term      = s_ack_i | s_err_i | s_rty_i;
  assign busy      = (state_q == BUSY) && !rst_bus;
  assign abort_err = (state_q == ABORT) && err_pulse_q && !rst_bus;

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = m0_adr_i;
    s_sel_o = m0_sel_i;
    s_dat_o = m0_dat_i;
    if (state_q != IDLE) begin
      s_adr_o = own_adr;
      s_sel_o = own_sel;
      s_dat_o = own_dat;
    end
    if (busy) begin
      s_cyc_o = own_cyc;
      s_stb_o = own_stb;
      s_we_o  = own_we;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign m0_ack_o = busy && !owner_q && s_ack_i;
  assign m0_rty_o = busy && !owner_q && s_rty_i;
  assign m0_err_o = !owner_q && ((busy && s_err_i) || abort_err);
  assign m1_ack_o = busy && owner_q && s_ack_i;
  assign m1_rty_o = busy && owner_q && s_rty_i;
  assign m1_err_o = owner_q && ((busy && s_err_i) || abort_err);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wdog_d      = wdog_q;
    err_pulse_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i || m1_cyc_i) begin
          owner_d = grant;
          last_d  = grant;
          wdog_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          wdog_d  = '0;
          state_d = IDLE;
        end else if (own_stb && !term) begin
          // A termination in the firing cycle takes the else branch and wins.
          if ((TIMEOUT != 0) && (wdog_q == WDOG_LAST)) begin
            wdog_d      = '0;
            err_pulse_d = 1'b1;
            state_d     = ABORT;
          end else if (wdog_q != WDOG_MAX) begin
            wdog_d = wdog_q + 1'b1;
          end
        end else begin
          wdog_d = '0;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_bus) begin
    if (rst_bus) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= '1;
      wdog_q      <= '0;
      err_pulse_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wdog_q      <= wdog_d;
      err_pulse_q <= err_pulse_d;
    end
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Scoreboard bench for wb_ram_arbiter: per-master expected responses and an
// expected grant order, checked against what the DUT actually routes.
module tb_wb_ram_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned TIMEOUT = 4;
  localparam logic [31:0] RD_KEY  = 32'hC0DE_0000;
  localparam logic [31:0] WR_KEY  = 32'h1357_9BDF;
  localparam logic [2:0]  R_ACK   = 3'b100;
  localparam logic [2:0]  R_ERR   = 3'b010;
  localparam logic [2:0]  R_RTY   = 3'b001;
  localparam int MODE_ACK = 0, MODE_ERR = 1, MODE_RTY = 2, MODE_HANG = 3;

  logic        clk_bus = 1'b0;
  logic        rst_bus;
  logic        mcyc [2];
  logic        mstb [2];
  logic        mwe  [2];
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic [3:0]  msel [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o;
  logic        m1_ack_o, m1_err_o, m1_rty_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i, s_rty_i;

  typedef struct {
    logic [2:0]  resp;
    logic        wd;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  int   exp_grant [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   slv_mode  = MODE_ACK;
  int   slv_delay = 0;

  wb_ram_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_bus(clk_bus), .rst_bus(rst_bus),
    .m0_cyc_i(mcyc[0]), .m0_stb_i(mstb[0]), .m0_we_i(mwe[0]), .m0_adr_i(madr[0]),
    .m0_sel_i(msel[0]), .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_cyc_i(mcyc[1]), .m1_stb_i(mstb[1]), .m1_we_i(mwe[1]), .m1_adr_i(madr[1]),
    .m1_sel_i(msel[1]), .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  initial forever #5 clk_bus = ~clk_bus;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] resp_of(input int m);
    return (m == 0) ? {m0_ack_o, m0_err_o, m0_rty_o} : {m1_ack_o, m1_err_o, m1_rty_o};
  endfunction

  function automatic logic [31:0] ctl_bits();
    return {29'b0, s_cyc_o, s_stb_o, s_we_o};
  endfunction

  function automatic logic [31:0] all_resp();
    return {26'b0, resp_of(1), resp_of(0)};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_bus);
    #1;
  endtask

  // One locked bus cycle of n strobed transfers, then hold cycles with cyc still high.
  task automatic m_cycle(input int m, input int n, input logic we, input logic [31:0] adr0,
                         input logic [3:0] sel, input int hold);
    exp_t        e;
    logic [31:0] a;
    bit          seen;
    @(posedge clk_bus);
    #1;
    mcyc[m] = 1'b1;
    mwe[m]  = we;
    msel[m] = sel;
    for (int k = 0; k < n; k++) begin
      a       = adr0 + 32'(4 * k);
      madr[m] = a;
      mdat[m] = a ^ WR_KEY;
      mstb[m] = 1'b1;
      e.resp  = (slv_mode == MODE_ACK) ? R_ACK : (slv_mode == MODE_RTY) ? R_RTY : R_ERR;
      e.wd    = (slv_mode == MODE_HANG);
      e.we    = we;
      e.adr   = a;
      e.sel   = sel;
      e.dat   = we ? (a ^ WR_KEY) : (a ^ RD_KEY);
      if (m == 0) q0.push_back(e);
      else        q1.push_back(e);
      seen = 1'b0;
      for (int t = 0; t < 60 && !seen; t++) begin
        @(negedge clk_bus);
        if (resp_of(m) != 3'b000) seen = 1'b1;
      end
      if (!seen) check_eq("resp_timeout", 32'(seen), 32'd1);
      @(posedge clk_bus);
      #1;
    end
    mstb[m] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_bus);
      #1;
    end
    mcyc[m] = 1'b0;
  endtask

  initial begin : slave
    int wait_cnt;
    wait_cnt = 0;
    s_ack_i  = 1'b0;
    s_err_i  = 1'b0;
    s_rty_i  = 1'b0;
    s_dat_i  = '0;
    forever begin
      @(posedge clk_bus);
      #2;
      s_ack_i = 1'b0;
      s_err_i = 1'b0;
      s_rty_i = 1'b0;
      if (s_cyc_o && s_stb_o) begin
        if (slv_mode != MODE_HANG && wait_cnt >= slv_delay) begin
          case (slv_mode)
            MODE_ACK: s_ack_i = 1'b1;
            MODE_ERR: s_err_i = 1'b1;
            default:  s_rty_i = 1'b1;
          endcase
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
      s_dat_i = s_adr_o ^ RD_KEY;
    end
  end

  initial begin : monitor
    logic prev_cyc;
    exp_t e;
    int   who;
    prev_cyc = 1'b0;
    forever begin
      @(negedge clk_bus);
      if (!rst_bus) begin
        if (s_cyc_o && !prev_cyc) begin
          who = s_adr_o[31] ? 0 : 1;
          if (exp_grant.size() == 0) check_eq("grant_unexpected", 32'(s_cyc_o), 32'd0);
          else check_eq("grant_order", 32'(who), 32'(exp_grant.pop_front()));
        end
        if (all_resp() != 32'd0) begin
          who = (resp_of(1) != 3'b000) ? 1 : 0;
          if ((who == 1 && q1.size() == 0) || (who == 0 && q0.size() == 0)) begin
            check_eq("resp_unexpected", all_resp(), 32'd0);
          end else begin
            if (who == 1) begin
              e = q1.pop_front();
              check_eq("m1_resp", all_resp(), {26'b0, e.resp, 3'b0});
            end else begin
              e = q0.pop_front();
              check_eq("m0_resp", all_resp(), {29'b0, e.resp});
            end
            if (!e.wd) begin
              check_eq("bus_adr", s_adr_o, e.adr);
              check_eq("bus_we", 32'(s_we_o), 32'(e.we));
              check_eq("bus_sel", 32'(s_sel_o), 32'(e.sel));
              if (e.we) check_eq("bus_wdat", s_dat_o, e.dat);
              else if (e.resp == R_ACK) check_eq("rd_data", (who == 1) ? m1_dat_o : m0_dat_o, e.dat);
            end
          end
        end
      end
      prev_cyc = s_cyc_o;
    end
  end

  initial begin : guard
    #50000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin : main
    rst_bus = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0;
      madr[i] = '0;   mdat[i] = '0;   msel[i] = '0;
    end
    idle(3);
    @(negedge clk_bus);
    check_eq("rst_ctl", ctl_bits(), 32'd0);
    check_eq("rst_resp", all_resp(), 32'd0);
    @(posedge clk_bus);
    #1;
    rst_bus = 1'b0;

    // m1 alone, slave acks two cycles after the strobe
    slv_mode = MODE_ACK; slv_delay = 2;
    exp_grant.push_back(1);
    fork
      m_cycle(1, 1, 1'b0, 32'h0000_0100, 4'hF, 0);
      begin
        @(posedge clk_bus);
        #2;
        check_eq("arb_lat_idle", 32'(s_cyc_o), 32'd0);
        @(posedge clk_bus);
        #2;
        check_eq("arb_lat_grant", 32'(s_cyc_o), 32'd1);
      end
    join
    idle(3);

    // reset while m0 is mid-read on a hung slave
    slv_mode = MODE_HANG;
    exp_grant.push_back(0);
    mcyc[0] = 1'b1; mstb[0] = 1'b1; mwe[0] = 1'b0; madr[0] = 32'h8000_0040; msel[0] = 4'hF;
    idle(2);
    @(negedge clk_bus);
    check_eq("rst_pre_busy", 32'(s_cyc_o), 32'd1);
    @(posedge clk_bus);
    #1;
    rst_bus = 1'b1;
    @(negedge clk_bus);
    check_eq("rst_mid_ctl", ctl_bits(), 32'd0);
    check_eq("rst_mid_resp", all_resp(), 32'd0);
    @(posedge clk_bus);
    #1;
    mcyc[0] = 1'b0; mstb[0] = 1'b0;
    @(negedge clk_bus);
    check_eq("rst_next_ctl", ctl_bits(), 32'd0);
    @(posedge clk_bus);
    #1;
    rst_bus = 1'b0;

    // tie straight after reset: m0, m1, m0
    slv_mode = MODE_ACK; slv_delay = 0;
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(0);
    fork
      begin
        m_cycle(0, 1, 1'b0, 32'h8000_0010, 4'hF, 0);
        m_cycle(0, 1, 1'b0, 32'h8000_0014, 4'hF, 0);
      end
      m_cycle(1, 1, 1'b0, 32'h0000_0110, 4'hF, 0);
    join
    idle(3);

    // locked cycle: three writes by m0 while m1 waits
    slv_delay = 1;
    exp_grant.push_back(0); exp_grant.push_back(1);
    fork
      m_cycle(0, 3, 1'b1, 32'h8000_0200, 4'b0011, 0);
      begin
        @(posedge clk_bus);
        m_cycle(1, 1, 1'b0, 32'h0000_0300, 4'hF, 0);
      end
    join
    idle(3);

    // watchdog on a hung slave, m1 queued behind
    slv_mode = MODE_HANG;
    exp_grant.push_back(0); exp_grant.push_back(1);
    fork
      m_cycle(0, 1, 1'b0, 32'h8000_0400, 4'hF, 3);
      begin
        @(posedge clk_bus);
        m_cycle(1, 1, 1'b0, 32'h0000_0500, 4'hF, 0);
      end
      begin
        int  n;
        bit  found;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
          @(negedge clk_bus);
          if (s_stb_o) found = 1'b1;
        end
        n = 0;
        found = 1'b0;
        for (int t = 0; t < 40 && !found; t++) begin
          @(negedge clk_bus);
          n++;
          if (m0_err_o) found = 1'b1;
        end
        check_eq("wd_latency", 32'(n), 32'(TIMEOUT));
        check_eq("wd_cyc_low0", 32'(s_cyc_o), 32'd0);
        @(negedge clk_bus);
        check_eq("wd_err_single", 32'(m0_err_o), 32'd0);
        check_eq("wd_cyc_low1", 32'(s_cyc_o), 32'd0);
        @(negedge clk_bus);
        check_eq("wd_cyc_low2", 32'(s_cyc_o), 32'd0);
      end
    join
    idle(3);

    // ack in the very cycle the watchdog would fire
    slv_mode = MODE_ACK; slv_delay = int'(TIMEOUT) - 1;
    exp_grant.push_back(0);
    m_cycle(0, 1, 1'b0, 32'h8000_0600, 4'hF, 0);
    idle(3);

    // slave err routed to m1, slave rty routed to m0
    slv_mode = MODE_ERR; slv_delay = 1;
    exp_grant.push_back(1);
    m_cycle(1, 1, 1'b0, 32'h0000_0700, 4'hF, 0);
    idle(3);
    slv_mode = MODE_RTY; slv_delay = 0;
    exp_grant.push_back(0);
    m_cycle(0, 1, 1'b1, 32'h8000_0800, 4'b1100, 0);
    idle(4);

    check_eq("sb_drain", 32'(q0.size() + q1.size() + exp_grant.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
